// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions: rotation amounts, PC-1/PC-2 tables,
// key/half-key/round-key types, FSM state encoding and small helper functions.
package des_pkg;

  typedef logic [63:0] des_key64_t;
  typedef logic [27:0] des_cd28_t;
  typedef logic [47:0] des_rk48_t;
  typedef logic [0:0]  des_state_t;

  localparam des_state_t ST_IDLE = 1'b0;
  localparam des_state_t ST_RUN  = 1'b1;

  localparam int unsigned SHIFT [1:16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Table entries use DES numbering: entry n selects bit n, bit 1 being the MSB.
  localparam int unsigned PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int unsigned PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  function automatic logic [1:0] shift_of(input logic [4:0] rnd);
    logic [1:0] amt;
    amt = 2'd0;
    for (int r = 1; r <= 16; r++) begin
      if (rnd == 5'(r)) amt = 2'(SHIFT[r]);
    end
    return amt;
  endfunction

  function automatic des_cd28_t rotl28(input des_cd28_t x, input logic [1:0] n);
    des_cd28_t y;
    case (n)
      2'd1:    y = {x[26:0], x[27]};
      2'd2:    y = {x[25:0], x[27:26]};
      default: y = x;
    endcase
    return y;
  endfunction

  function automatic des_cd28_t rotr28(input des_cd28_t x, input logic [1:0] n);
    des_cd28_t y;
    case (n)
      2'd1:    y = {x[0], x[27:1]};
      2'd2:    y = {x[1:0], x[27:2]};
      default: y = x;
    endcase
    return y;
  endfunction

  function automatic logic [55:0] pc1(input des_key64_t k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[6'(55 - i)] = k[6'(64 - PC1[i])];
    return r;
  endfunction

  function automatic des_rk48_t pc2(input logic [55:0] cd);
    des_rk48_t r;
    r = '0;
    for (int i = 0; i < 48; i++) r[6'(47 - i)] = cd[6'(56 - PC2[i])];
    return r;
  endfunction

  // True when every byte carries odd parity, as DES keys are meant to.
  function automatic logic key_bytes_odd(input des_key64_t k);
    des_key64_t t;
    logic       ok;
    t  = k;
    ok = 1'b1;
    for (int b = 0; b < 8; b++) begin
      if (!(^t[7:0])) ok = 1'b0;
      t = t >> 8;
    end
    return ok;
  endfunction

endpackage

// File: rtl/des_key_schedule_seq_if.sv
// Key-load, run-request and round-key stream signals between the key
// scheduler (slave) and its controller / round engine (master).
interface des_key_schedule_seq_if
  import des_pkg::*;
#(
  parameter int IDX_W = 2
);
  logic             key_wr;
  logic [IDX_W-1:0] key_wr_idx;
  des_key64_t       key_wr_data;
  logic             start;
  logic [IDX_W-1:0] start_idx;
  logic             start_decrypt;
  logic             busy;
  logic             rk_valid;
  logic             rk_ready;
  des_rk48_t        rk_data;
  logic [3:0]       rk_round;
  logic             rk_last;
  logic             done;

  modport master (
    output key_wr, key_wr_idx, key_wr_data, start, start_idx, start_decrypt, rk_ready,
    input  busy, rk_valid, rk_data, rk_round, rk_last, done
  );

  modport slave (
    input  key_wr, key_wr_idx, key_wr_data, start, start_idx, start_decrypt, rk_ready,
    output busy, rk_valid, rk_data, rk_round, rk_last, done
  );
endinterface

// File: rtl/des_pc2_perm.sv
// Combinational DES PC-2 permutation, 56-bit C||D to 48-bit round key.
module des_pc2_perm
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output des_rk48_t   rk
);
  always_comb begin
    rk = pc2(cd);
  end
endmodule

// File: rtl/des_key_schedule_seq.sv
// Multi-slot iterative DES round-key generator streaming 16 keys per run.
// Optional macro DES_KEY_PARITY_CHK_EN adds a sticky key-parity error flag.
module des_key_schedule_seq
  import des_pkg::*;
#(
  parameter int NUM_KEYS = 3,
  parameter int ROUNDS   = 16,
  localparam int IDX_W   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
)
(
  input  logic clk,
  input  logic rst,
  des_key_schedule_seq_if.slave bus
`ifdef DES_KEY_PARITY_CHK_EN
  ,
  output logic parity_err
`endif
);

  des_key64_t          slot_reg [NUM_KEYS];
  logic [NUM_KEYS-1:0] slot_we;

  des_state_t state_reg;
  des_cd28_t  c_reg, d_reg, c_next, d_next;
  logic [4:0] rnd_reg;
  logic       dec_reg;
  logic       rk_valid_reg, rk_last_reg, done_reg;
  des_rk48_t  rk_data_reg, rk_next;
  logic [3:0] rk_round_reg, round_next;
  logic       rk_free;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_slot_we
    assign slot_we[gi] = bus.key_wr && (bus.key_wr_idx == IDX_W'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) slot_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        if (slot_we[i]) slot_reg[i] <= bus.key_wr_data;
      end
    end
  end

  // Decrypt walks the schedule backwards: round 1 of a decrypt run is K16,
  // which equals the PC-1 output itself since the total shift is 28.
  always_comb begin
    c_next     = c_reg;
    d_next     = d_reg;
    round_next = 4'(rnd_reg - 5'd1);
    if (!dec_reg) begin
      c_next = rotl28(c_reg, shift_of(rnd_reg));
      d_next = rotl28(d_reg, shift_of(rnd_reg));
    end else begin
      round_next = 4'(5'(ROUNDS) - rnd_reg);
      if (rnd_reg != 5'd1) begin
        c_next = rotr28(c_reg, shift_of(5'(ROUNDS + 2) - rnd_reg));
        d_next = rotr28(d_reg, shift_of(5'(ROUNDS + 2) - rnd_reg));
      end
    end
  end

  des_pc2_perm u_pc2 (
    .cd ({c_next, d_next}),
    .rk (rk_next)
  );

  assign rk_free = !rk_valid_reg || bus.rk_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      c_reg        <= '0;
      d_reg        <= '0;
      rnd_reg      <= '0;
      dec_reg      <= 1'b0;
      rk_valid_reg <= 1'b0;
      rk_data_reg  <= '0;
      rk_round_reg <= '0;
      rk_last_reg  <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            {c_reg, d_reg} <= pc1(slot_reg[bus.start_idx]);
            rnd_reg        <= 5'd1;
            dec_reg        <= bus.start_decrypt;
            state_reg      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (rk_free) begin
            if (rnd_reg <= 5'(ROUNDS)) begin
              c_reg        <= c_next;
              d_reg        <= d_next;
              rk_data_reg  <= rk_next;
              rk_round_reg <= round_next;
              rk_last_reg  <= (rnd_reg == 5'(ROUNDS));
              rk_valid_reg <= 1'b1;
              rnd_reg      <= rnd_reg + 5'd1;
            end else begin
              rk_valid_reg <= 1'b0;
              rk_last_reg  <= 1'b0;
            end
          end
          if (rk_valid_reg && bus.rk_ready && rk_last_reg) begin
            done_reg  <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state_reg == ST_RUN);
  assign bus.rk_valid = rk_valid_reg;
  assign bus.rk_data  = rk_data_reg;
  assign bus.rk_round = rk_round_reg;
  assign bus.rk_last  = rk_last_reg;
  assign bus.done     = done_reg;

`ifdef DES_KEY_PARITY_CHK_EN
  logic parity_err_reg;

  // The key is stored regardless; the flag only records that a bad one was seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_reg <= 1'b0;
    end else if (bus.key_wr && !key_bytes_odd(bus.key_wr_data)) begin
      parity_err_reg <= 1'b1;
    end
  end

  assign parity_err = parity_err_reg;
`endif

endmodule

// File: tb/tb_des_key_schedule_seq.sv
// Randomized self-checking bench for des_key_schedule_seq against a
// cumulative-shift DES key-schedule reference model.
module tb_des_key_schedule_seq;
  localparam int NK = 3;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  des_key_schedule_seq_if #(.IDX_W(IW)) bus();
`ifdef DES_KEY_PARITY_CHK_EN
  logic parity_err;
`endif

  des_key_schedule_seq #(.NUM_KEYS(NK), .ROUNDS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DES_KEY_PARITY_CHK_EN
    ,
    .parity_err (parity_err)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] slot_m [NK];
  logic [47:0] got_rk [16];

  int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  // Total left rotation of C and D after rounds 1..16.
  int cum_t [16] = '{1,2,4,6,8,10,12,14,15,17,19,21,23,25,27,28};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Round key for round index r (0..15) computed straight from the DES definition.
  function automatic logic [47:0] ref_rk(input logic [63:0] key, input int r);
    logic [55:0] cd;
    logic [27:0] c, d;
    logic [47:0] o;
    int s;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-pc1_t[i]];
    s = cum_t[r];
    c = cd[55:28];
    d = cd[27:0];
    c = (c << s) | (c >> (28 - s));
    d = (d << s) | (d >> (28 - s));
    cd = {c, d};
    for (int i = 0; i < 48; i++) o[47-i] = cd[56-pc2_t[i]];
    return o;
  endfunction

  task automatic write_key(input int idx, input logic [63:0] data);
    @(negedge clk);
    bus.key_wr = 1'b1;
    bus.key_wr_idx = IW'(idx);
    bus.key_wr_data = data;
    @(negedge clk);
    bus.key_wr = 1'b0;
    slot_m[idx] = data;
    $display("write slot=%0d key=%h", idx, data);
  endtask

  task automatic run(input int idx, input bit dec, input int stall_pct,
                     input bit mid_evt, input bit wr_same, input int abort_at);
    logic [63:0] key;
    logic [63:0] wdata;
    logic [47:0] held_d;
    logic [3:0]  held_r;
    bit pend, aborted;
    int got, cyc, first_lat, exp_r, done_seen;
    key = slot_m[idx];
    @(negedge clk);
    bus.start = 1'b1;
    bus.start_idx = IW'(idx);
    bus.start_decrypt = dec;
    bus.rk_ready = 1'b0;
    if (wr_same) begin
      wdata = {$urandom, $urandom};
      bus.key_wr = 1'b1;
      bus.key_wr_idx = IW'(idx);
      bus.key_wr_data = wdata;
      slot_m[idx] = wdata;
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.key_wr = 1'b0;
    chk("busy_at_start", bus.busy, 1);
    chk("valid_before_first", bus.rk_valid, 0);
    got = 0; cyc = 0; pend = 0; aborted = 0; done_seen = 0; first_lat = -1;
    while (got < 16 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (bus.done) done_seen++;
      if (bus.rk_valid && first_lat < 0) first_lat = cyc;
      if (pend) begin
        chk("hold_valid", bus.rk_valid, 1);
        chk("hold_data", bus.rk_data, held_d);
        chk("hold_round", bus.rk_round, held_r);
      end
      if (abort_at > 0 && got == abort_at - 1 && bus.rk_valid) begin
        rst = 1'b1;
        #1;
        chk("abort_valid", bus.rk_valid, 0);
        chk("abort_data", bus.rk_data, 0);
        chk("abort_round", bus.rk_round, 0);
        chk("abort_last", bus.rk_last, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        aborted = 1;
        break;
      end
      if (mid_evt && cyc == 3) begin
        wdata = {$urandom, $urandom};
        bus.start = 1'b1;
        bus.start_idx = IW'((idx + 1) % NK);
        bus.start_decrypt = ~dec;
        bus.key_wr = 1'b1;
        bus.key_wr_idx = IW'(idx);
        bus.key_wr_data = wdata;
        slot_m[idx] = wdata;
      end else begin
        bus.start = 1'b0;
        bus.key_wr = 1'b0;
      end
      bus.rk_ready = ($urandom_range(99) >= stall_pct);
      if (bus.rk_valid) begin
        if (bus.rk_ready) begin
          exp_r = dec ? 15 - got : got;
          chk("rk_data", bus.rk_data, ref_rk(key, exp_r));
          chk("rk_round", bus.rk_round, exp_r);
          chk("rk_last", bus.rk_last, got == 15);
          got_rk[got] = bus.rk_data;
          got++;
          pend = 0;
        end else begin
          pend = 1;
          held_d = bus.rk_data;
          held_r = bus.rk_round;
        end
      end
    end
    if (aborted) begin
      @(negedge clk);
      rst = 1'b0;
      bus.rk_ready = 1'b0;
      for (int i = 0; i < NK; i++) slot_m[i] = '0;
      repeat (3) begin
        @(negedge clk);
        if (bus.done) done_seen++;
      end
      chk("no_done_after_abort", done_seen, 0);
    end else begin
      chk("key_count", got, 16);
      chk("first_latency", first_lat, 1);
      chk("done_before_end", done_seen, 0);
      if (stall_pct == 0) chk("back_to_back", cyc, 16);
      bus.start = 1'b0;
      bus.key_wr = 1'b0;
      @(negedge clk);
      bus.rk_ready = 1'b0;
      chk("done_pulse", bus.done, 1);
      chk("busy_at_done", bus.busy, 0);
      chk("valid_after_run", bus.rk_valid, 0);
      @(negedge clk);
      chk("done_single", bus.done, 0);
      chk("busy_idle", bus.busy, 0);
    end
    $display("run slot=%0d dec=%0d stall=%0d keys=%0d cycles=%0d aborted=%0d",
             idx, dec, stall_pct, got, cyc, aborted);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.key_wr = 1'b0; bus.key_wr_idx = '0; bus.key_wr_data = '0;
    bus.start = 1'b0; bus.start_idx = '0; bus.start_decrypt = 1'b0; bus.rk_ready = 1'b0;
    for (int i = 0; i < NK; i++) slot_m[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.rk_valid, 0);
    chk("rst_data", bus.rk_data, 0);
    chk("rst_round", bus.rk_round, 0);
    chk("rst_last", bus.rk_last, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
`ifdef DES_KEY_PARITY_CHK_EN
    chk("rst_parity", parity_err, 0);
`endif
    rst = 1'b0;

    write_key(0, 64'h133457799BBCDFF1);
    write_key(1, {$urandom, $urandom});
    write_key(2, {$urandom, $urandom});

    run(0, 1'b0, 0, 1'b0, 1'b0, 0);
    chk("gold_enc_first", got_rk[0], 48'h1B02EFFC7072);
    chk("gold_enc_last", got_rk[15], 48'hCB3D8B0E17F5);

    run(0, 1'b1, 0, 1'b0, 1'b0, 0);
    chk("gold_dec_first", got_rk[0], 48'hCB3D8B0E17F5);
    chk("gold_dec_last", got_rk[15], 48'h1B02EFFC7072);

    run(0, 1'b0, 40, 1'b0, 1'b0, 0);
    chk("gold_stall_first", got_rk[0], 48'h1B02EFFC7072);
    chk("gold_stall_last", got_rk[15], 48'hCB3D8B0E17F5);

    run(0, 1'b0, 30, 1'b1, 1'b0, 0);
    run(1, 1'b1, 30, 1'b1, 1'b0, 0);
    run(2, 1'b0, 30, 1'b0, 1'b0, 0);
    run(1, 1'b0, 20, 1'b0, 1'b1, 0);
    run(1, 1'b0, 0, 1'b0, 1'b0, 0);

    run(2, 1'b0, 0, 1'b0, 1'b0, 7);
    run(0, 1'b0, 0, 1'b0, 1'b0, 0);
    run(2, 1'b1, 25, 1'b0, 1'b0, 0);

    for (int t = 0; t < 6; t++) begin
      if ($urandom_range(1)) write_key($urandom_range(NK - 1), {$urandom, $urandom});
      run($urandom_range(NK - 1), 1'($urandom_range(1)), $urandom_range(60), 1'($urandom_range(1)), 1'b0, 0);
    end

`ifdef DES_KEY_PARITY_CHK_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    write_key(0, 64'h0101010101010101);
    chk("parity_good", parity_err, 0);
    write_key(1, 64'h0001010101010101);
    chk("parity_bad", parity_err, 1);
    write_key(2, 64'h0101010101010101);
    chk("parity_sticky", parity_err, 1);
    run(1, 1'b0, 0, 1'b0, 1'b0, 0);
    chk("parity_after_run", parity_err, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("parity_cleared", parity_err, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
